muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit producing HI/LO results for the execute stage. It is the multi-cycle successor to the single-cycle ALU multiply path. Signed and unsigned multiply and divide take a start/busy/done handshake, so the pipeline can stall on `busy` and flush an in-flight operation with `cancel`. HI/LO outputs are registered and hold until the next completed operation.

---
 rtl/muldiv_if.sv | 18 +
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Execute-stage handshake bundle for the multiply/divide unit.
// The pipeline side drives the request; the unit drives busy/done and the HI/LO results.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) producing HI/LO.
// Defining MULDIV_FAST_MUL_EN swaps the iterative multiply for a single-cycle native multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     resetn,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_q;
  logic               neg_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     prem;

  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, shifted, diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Signed ops work on magnitudes; the most-negative value keeps its unsigned magnitude.
  always_comb begin
    a_neg    = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg    = ~bus.op[0] & bus.b[WIDTH-1];
    abs_a    = a_neg ? -bus.a : bus.a;
    abs_b    = b_neg ? -bus.b : bus.b;
    div_zero = bus.op[1] & (bus.b == '0);
  end

  // Multiply keeps the multiplier in acc's low half; divide keeps the dividend there.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    shifted  = {prem[WIDTH-1:0], acc[WIDTH-1]};
    diff     = shifted - {1'b0, mag_b};
    prod_fix = (neg_q & ~op_r[0]) ? -acc : acc;
    quo_fix  = (neg_q & ~op_r[0]) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = (neg_r & ~op_r[0]) ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

  always_comb begin
    ext_a     = bus.op[0] ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
    ext_b     = bus.op[0] ? {{WIDTH{1'b0}}, bus.b} : {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    fast_prod = ext_a * ext_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      op_r     <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      prem     <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.cancel) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              op_r  <= bus.op;
              mag_a <= abs_a;
              mag_b <= abs_b;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg & bus.op[1];
              cnt   <= '0;
              acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
              prem  <= '0;
              if (div_zero) begin
                state    <= DONE;
                bus.done <= 1'b1;
                bus.hi   <= bus.a;
                bus.lo   <= '1;
              end
`ifdef MULDIV_FAST_MUL_EN
              else if (!bus.op[1]) begin
                state    <= DONE;
                bus.done <= 1'b1;
                {bus.hi, bus.lo} <= fast_prod;
              end
`endif
              else begin
                state    <= CALC;
                bus.busy <= 1'b1;
              end
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            if (op_r[1]) begin
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~diff[WIDTH]};
              prem           <= diff[WIDTH] ? shifted : diff;
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
          FIX: begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            if (op_r[1]) begin
              bus.hi <= rem_fix;
              bus.lo <= quo_fix;
            end else begin
              {bus.hi, bus.lo} <= prod_fix;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   passed = 0;
  logic [W-1:0] lastHi = '0;
  logic [W-1:0] lastLo = '0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} straight from the arithmetic definition of each op.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (op == 2'b00) return 64'(sa * sb);
    if (op == 2'b01) return ua * ub;
    if (b == '0) return {a, {W{1'b1}}};
    if (op == 2'b10) return {W'(sa % sb), W'(sa / sb)};
    return {W'(ua % ub), W'(ua / ub)};
  endfunction

  function automatic int expLatency(input logic [1:0] op, input logic [W-1:0] b);
    if (op[1] && b == '0) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) return 1;
`endif
    return W + 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Launches one op, optionally injects a stray start while busy, and checks timing and results.
  task automatic runOp(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit pulseCheck, input int injectAt);
    logic [63:0] exp;
    int          lat, n;
    logic        firstBusy;
    exp = refModel(op, a, b);
    lat = expLatency(op, b);
    applyStimulus(op, a, b);
    firstBusy = bus.busy;
    n = 0;
    while (bus.done !== 1'b1 && n < W + 10) begin
      if (n == injectAt) begin
        bus.a     = ~a;
        bus.b     = b ^ 32'h1;
        bus.start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    checkOutput($sformatf("%s/latency", name), 64'(n + 1), 64'(lat));
    checkOutput($sformatf("%s/busyFirst", name), 64'(firstBusy), 64'(lat > 1));
    checkOutput($sformatf("%s/busyAtDone", name), 64'(bus.busy), 64'(0));
    checkOutput($sformatf("%s/hi", name), 64'(bus.hi), 64'(exp[63:32]));
    checkOutput($sformatf("%s/lo", name), 64'(bus.lo), 64'(exp[31:0]));
    lastHi = exp[63:32];
    lastLo = exp[31:0];
    if (pulseCheck) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("%s/donePulse", name), 64'(bus.done), 64'(0));
      checkOutput($sformatf("%s/hold", name), {bus.hi, bus.lo}, {lastHi, lastLo});
    end
  endtask

  function automatic logic [W-1:0] pickOperand(input int sel);
    case (sel)
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic sawDone;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = '0;
    bus.a      = '0;
    bus.b      = '0;
    resetn     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("reset/hi", 64'(bus.hi), 64'(0));
    checkOutput("reset/lo", 64'(bus.lo), 64'(0));
    checkOutput("reset/busy", 64'(bus.busy), 64'(0));
    checkOutput("reset/done", 64'(bus.done), 64'(0));

    runOp("multuMax", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1);
    runOp("multNeg", 2'b00, 32'hFFFF_FFFD, 32'd5, 1, -1);
    runOp("divNeg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1, -1);
    runOp("divu", 2'b11, 32'd100, 32'd7, 1, -1);
    runOp("divMinByM1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1);
    runOp("divuByZero", 2'b11, 32'd5, 32'd0, 1, -1);
    runOp("divByZero", 2'b10, 32'hFFFF_FF00, 32'd0, 1, -1);

    // Cancel mid-divide: no done, results stay at the previous op's values.
    applyStimulus(2'b11, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cancel = 1'b0;
    checkOutput("cancel/busy", 64'(bus.busy), 64'(0));
    sawDone = bus.done;
    repeat (W + 5) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("cancel/noDone", 64'(sawDone), 64'(0));
    checkOutput("cancel/hold", {bus.hi, bus.lo}, {lastHi, lastLo});

    runOp("ignoredStart", 2'b11, 32'd1000, 32'd33, 1, 4);
    runOp("b2bFirst", 2'b11, 32'd100, 32'd7, 0, -1);
    runOp("b2bSecond", 2'b10, 32'hFFFF_FFF9, 32'd2, 1, -1);

    // Reset while busy returns to the reset state.
    applyStimulus(2'b10, 32'd12345, 32'd17);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("midReset/busy", 64'(bus.busy), 64'(0));
    checkOutput("midReset/done", 64'(bus.done), 64'(0));
    checkOutput("midReset/hilo", {bus.hi, bus.lo}, 64'(0));

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = pickOperand(int'($urandom_range(0, 7)));
      rb  = pickOperand(int'($urandom_range(0, 7)));
      runOp($sformatf("rand%0d", i), rop, ra, rb, (i % 2) == 0, -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
